// File: rtl/gb_regfile.sv
// rtl/gb_regfile.sv - byte/pair register file with flag masking and pair inc/dec
//
// Register file of NUM_REGS bytes, WIDTH bits each. Pair p is byte 2p (high half)
// and byte 2p+1 (low half). Byte FLAG_REG only ever stores bits set in FLAG_MASK.
// All reads are combinational from stored state. Updates take one clock edge.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, clears all registers
//   rd_a_sel   in   SW        byte read select A
//   rd_a_data  out  WIDTH     byte read data A (0 when select out of range)
//   rd_b_sel   in   SW        byte read select B
//   rd_b_data  out  WIDTH     byte read data B (0 when select out of range)
//   rdp_sel    in   PW        pair read select
//   rdp_data   out  2*WIDTH   pair read data {byte 2p, byte 2p+1}
//   wr_en      in   1         byte write enable
//   wr_sel     in   SW        byte write select
//   wr_data    in   WIDTH     byte write data
//   wrp_en     in   1         pair write enable
//   wrp_sel    in   PW        pair write select
//   wrp_data   in   2*WIDTH   pair write data
//   idp_en     in   1         pair increment/decrement enable
//   idp_sel    in   PW        pair inc/dec select
//   idp_dec    in   1         0 = increment, 1 = decrement
//   zero       out  1         stored pair idp_sel equals 0

module gb_regfile #(
   parameter int               WIDTH     = 8,
   parameter int               NUM_REGS  = 8,
   parameter int               FLAG_REG  = 1,
   parameter logic [WIDTH-1:0] FLAG_MASK = WIDTH'(8'hF0),
   localparam int              SW        = ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS),
   localparam int              PW        = ($clog2(NUM_REGS / 2) < 1) ? 1 : $clog2(NUM_REGS / 2)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SW-1:0]        rd_a_sel,
   output logic [WIDTH-1:0]     rd_a_data,
   input  logic [SW-1:0]        rd_b_sel,
   output logic [WIDTH-1:0]     rd_b_data,
   input  logic [PW-1:0]        rdp_sel,
   output logic [2*WIDTH-1:0]   rdp_data,
   input  logic                 wr_en,
   input  logic [SW-1:0]        wr_sel,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 wrp_en,
   input  logic [PW-1:0]        wrp_sel,
   input  logic [2*WIDTH-1:0]   wrp_data,
   input  logic                 idp_en,
   input  logic [PW-1:0]        idp_sel,
   input  logic                 idp_dec,
   output logic                 zero
);

   localparam int                 NP       = NUM_REGS / 2;
   localparam logic [2*WIDTH-1:0] PAIR_ONE = (2*WIDTH)'(1);

   logic [WIDTH-1:0]   regs_q [NUM_REGS];
   logic [WIDTH-1:0]   regs_d [NUM_REGS];
   logic [2*WIDTH-1:0] idp_cur;
   logic [2*WIDTH-1:0] idp_res;
   logic               wrp_ok;
   logic               idp_ok;

   // Reads select by comparison against every index so out-of-range
   // selects simply match nothing and return 0.
   always_comb begin : read_ports
      rd_a_data = '0;
      rd_b_data = '0;
      rdp_data  = '0;
      idp_cur   = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(rd_a_sel) == i) rd_a_data = regs_q[i];
         if (int'(rd_b_sel) == i) rd_b_data = regs_q[i];
      end
      for (int p = 0; p < NP; p++) begin
         if (int'(rdp_sel) == p) rdp_data = {regs_q[2*p], regs_q[2*p+1]};
         if (int'(idp_sel) == p) idp_cur  = {regs_q[2*p], regs_q[2*p+1]};
      end
   end

   assign zero = (idp_cur == '0);

   // Byte priority wrp > idp > wr: each byte takes the lowest-priority hit
   // first and is overridden by higher ones. A wrp to the idp pair covers
   // both bytes, so the idp is discarded as a whole.
   always_comb begin : next_state
      idp_res = idp_dec ? (idp_cur - PAIR_ONE) : (idp_cur + PAIR_ONE);
      wrp_ok  = wrp_en && (int'(wrp_sel) < NP);
      idp_ok  = idp_en && (int'(idp_sel) < NP) && !(wrp_ok && (wrp_sel == idp_sel));
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_en && (int'(wr_sel) == i)) begin
            regs_d[i] = wr_data;
         end
         if (idp_ok && (int'(idp_sel) == i / 2)) begin
            regs_d[i] = (i % 2 == 0) ? idp_res[2*WIDTH-1:WIDTH] : idp_res[WIDTH-1:0];
         end
         if (wrp_ok && (int'(wrp_sel) == i / 2)) begin
            regs_d[i] = (i % 2 == 0) ? wrp_data[2*WIDTH-1:WIDTH] : wrp_data[WIDTH-1:0];
         end
         // Flag byte is masked on the way in, so stored value and reads
         // never carry non-mask bits.
         if (i == FLAG_REG) begin
            regs_d[i] = regs_d[i] & FLAG_MASK;
         end
         if (rst) begin
            regs_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_q[i] <= regs_d[i];
      end
   end

endmodule

// File: tb/tb_gb_regfile.sv
// tb/tb_gb_regfile.sv - self-checking bench for gb_regfile

module tb_gb_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  rd_a_sel = '0, rd_b_sel = '0, wr_sel = '0;
   logic [1:0]  rdp_sel = '0, wrp_sel = '0, idp_sel = '0;
   logic [7:0]  rd_a_data, rd_b_data, wr_data = '0;
   logic [15:0] rdp_data, wrp_data = '0;
   logic        wr_en = 1'b0, wrp_en = 1'b0, idp_en = 1'b0, idp_dec = 1'b0;
   logic        zero;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic [7:0] model [8];

   always #5 clk = ~clk;

   gb_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .rd_a_sel  (rd_a_sel),
      .rd_a_data (rd_a_data),
      .rd_b_sel  (rd_b_sel),
      .rd_b_data (rd_b_data),
      .rdp_sel   (rdp_sel),
      .rdp_data  (rdp_data),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .wrp_en    (wrp_en),
      .wrp_sel   (wrp_sel),
      .wrp_data  (wrp_data),
      .idp_en    (idp_en),
      .idp_sel   (idp_sel),
      .idp_dec   (idp_dec),
      .zero      (zero)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_pair(input logic [1:0] p);
      return {model[2*p], model[2*p+1]};
   endfunction

   // Model: each byte's new value is chosen by an explicit precedence
   // chain on the pre-edge state; the flag byte is masked afterwards.
   always @(posedge clk) begin
      logic [7:0]  nxt [8];
      logic [15:0] pv;
      int          p;
      if (rst) begin
         for (int b = 0; b < 8; b++) model[b] = 8'h00;
      end else begin
         pv = model_pair(idp_sel);
         pv = idp_dec ? pv - 16'd1 : pv + 16'd1;
         for (int b = 0; b < 8; b++) begin
            p = b / 2;
            if (wrp_en && int'(wrp_sel) == p)
               nxt[b] = (b % 2 == 0) ? wrp_data[15:8] : wrp_data[7:0];
            else if (idp_en && int'(idp_sel) == p)
               nxt[b] = (b % 2 == 0) ? pv[15:8] : pv[7:0];
            else if (wr_en && int'(wr_sel) == b)
               nxt[b] = wr_data;
            else
               nxt[b] = model[b];
         end
         nxt[1] = nxt[1] & 8'hF0;
         for (int b = 0; b < 8; b++) model[b] = nxt[b];
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_rd_a", rd_a_data, model[rd_a_sel]);
         chk("cmp_rd_b", rd_b_data, model[rd_b_sel]);
         chk("cmp_rdp", rdp_data, model_pair(rdp_sel));
         chk("cmp_zero", zero, model_pair(idp_sel) == 16'h0000);
      end
   end

   task automatic go();
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      wrp_en  = 1'b0;
      idp_en  = 1'b0;
      idp_dec = 1'b0;
      rst     = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 8; i += 2) begin
         rd_a_sel = 3'(i);
         rd_b_sel = 3'(i + 1);
         rdp_sel  = 2'(i / 2);
         idp_sel  = 2'(i / 2);
         #1;
         chk({tag, "_a"}, rd_a_data, 32'h0);
         chk({tag, "_b"}, rd_b_data, 32'h0);
         chk({tag, "_pair"}, rdp_data, 32'h0);
         chk({tag, "_zero"}, zero, 32'h1);
         go();
      end
   endtask

   initial begin
      rst = 1'b1;
      go();
      chk_en = 1'b1;
      check_all_zero("rst");

      // Pair write into AF: flag low nibble masked.
      wrp_en = 1'b1; wrp_sel = 2'd0; wrp_data = 16'h12FF;
      go();
      rd_a_sel = 3'd0; rd_b_sel = 3'd1; rdp_sel = 2'd0; #1;
      chk("af_a", rd_a_data, 32'h12);
      chk("af_f", rd_b_data, 32'hF0);
      chk("af_pair", rdp_data, 32'h12F0);

      // HL wrap both directions.
      wrp_en = 1'b1; wrp_sel = 2'd3; wrp_data = 16'hFFFF;
      go();
      idp_en = 1'b1; idp_sel = 2'd3;
      go();
      rdp_sel = 2'd3; #1;
      chk("hl_inc_wrap", rdp_data, 32'h0000);
      chk("hl_inc_zero", zero, 32'h1);
      idp_en = 1'b1; idp_sel = 2'd3; idp_dec = 1'b1;
      go();
      #1;
      chk("hl_dec_wrap", rdp_data, 32'hFFFF);
      chk("hl_dec_zero", zero, 32'h0);

      // Overlapping wr L and idp HL: wr dropped, H still updates.
      wrp_en = 1'b1; wrp_sel = 2'd3; wrp_data = 16'h00FF;
      go();
      wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h55;
      idp_en = 1'b1; idp_sel = 2'd3;
      go();
      rdp_sel = 2'd3; #1;
      chk("hl_overlap", rdp_data, 32'h0100);
      wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h55;
      go();
      #1;
      chk("hl_wr_l", rdp_data, 32'h0155);

      // wrp BC beats idp BC; wr H is disjoint and lands.
      wrp_en = 1'b1; wrp_sel = 2'd1; wrp_data = 16'hABCD;
      idp_en = 1'b1; idp_sel = 2'd1; idp_dec = 1'b1;
      wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h77;
      go();
      rdp_sel = 2'd1; rd_a_sel = 3'd4; rd_b_sel = 3'd7; #1;
      chk("bc_wrp_wins", rdp_data, 32'hABCD);
      chk("h_wr", rd_a_data, 32'h77);
      chk("l_kept", rd_b_data, 32'h55);

      // Flag masking through byte write and inc/dec of AF.
      wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'hFF;
      go();
      rd_b_sel = 3'd1; rdp_sel = 2'd0; #1;
      chk("f_wr_mask", rd_b_data, 32'hF0);
      idp_en = 1'b1; idp_sel = 2'd0;
      go();
      #1;
      chk("af_inc_mask", rdp_data, 32'h12F0);
      idp_en = 1'b1; idp_sel = 2'd0; idp_dec = 1'b1;
      go();
      #1;
      chk("af_dec_mask", rdp_data, 32'h12E0);

      // Disjoint ops all take effect (HL = 7755 before).
      wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'hAA;
      wrp_en = 1'b1; wrp_sel = 2'd2; wrp_data = 16'h1234;
      idp_en = 1'b1; idp_sel = 2'd3;
      go();
      rd_a_sel = 3'd0; rd_b_sel = 3'd7; rdp_sel = 2'd2; #1;
      chk("dis_a", rd_a_data, 32'hAA);
      chk("dis_l", rd_b_data, 32'h56);
      chk("dis_de", rdp_data, 32'h1234);

      // Reset wins over a same-cycle pair write.
      rst = 1'b1; wrp_en = 1'b1; wrp_sel = 2'd0; wrp_data = 16'hBEEF;
      go();
      check_all_zero("rst_wrp");

      // Random traffic checked every cycle against the model.
      repeat (400) begin
         rst      = ($urandom_range(0, 63) == 0);
         wr_en    = 1'($urandom_range(0, 1));
         wr_sel   = 3'($urandom_range(0, 7));
         wr_data  = 8'($urandom);
         wrp_en   = ($urandom_range(0, 3) == 0);
         wrp_sel  = 2'($urandom_range(0, 3));
         wrp_data = 16'($urandom);
         idp_en   = 1'($urandom_range(0, 1));
         idp_sel  = 2'($urandom_range(0, 3));
         idp_dec  = 1'($urandom_range(0, 1));
         rd_a_sel = 3'($urandom_range(0, 7));
         rd_b_sel = 3'($urandom_range(0, 7));
         rdp_sel  = 2'($urandom_range(0, 3));
         go();
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gb_regfile.md
GB_REGFILE -- requirements
Module: gb_regfile

Interface
REQ-001 Parameter WIDTH, default 8: bits per register, min 4.
REQ-002 Parameter NUM_REGS, default 8: register count, even, min 2.
REQ-003 Parameter FLAG_REG, default 1: index of flag register; value >= NUM_REGS disables masking.
REQ-004 Parameter FLAG_MASK, default 8'hF0: bits of FLAG_REG that are writable; all others always read 0.
REQ-005 Derived widths: SW = clog2(NUM_REGS) and PW = clog2(NUM_REGS/2), each min 1.
REQ-006 Reset is rst, synchronous, active-high; clock is clk.
REQ-007 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-008 Port rst, input, 1: synchronous active-high reset.
REQ-009 Ports rd_a_sel, rd_b_sel, input, SW: byte read selects.
REQ-010 Ports rd_a_data, rd_b_data, output, WIDTH: byte read data.
REQ-011 Port rdp_sel, input, PW: pair read select.
REQ-012 Port rdp_data, output, 2*WIDTH: pair read data.
REQ-013 Ports wr_en (1), wr_sel (SW), wr_data (WIDTH), inputs: byte write.
REQ-014 Ports wrp_en (1), wrp_sel (PW), wrp_data (2*WIDTH), inputs: pair write.
REQ-015 Ports idp_en (1), idp_sel (PW), idp_dec (1), inputs: pair increment (idp_dec=0) or decrement (idp_dec=1).
REQ-016 Port zero, output, 1: high when pair idp_sel equals 0 in the current state.

Function
REQ-017 Pair p SHALL be byte 2p in the high half and byte 2p+1 in the low half; with the default parameters the pairs are AF, BC, DE, HL (A=0, F=1, ..., L=7).
REQ-018 All read ports SHALL be combinational from stored state only, with no write-to-read bypass; a write is visible one cycle after its edge.
REQ-019 A byte write SHALL update register wr_sel with wr_data at the edge when wr_en=1.
REQ-020 A pair write SHALL update both bytes of pair wrp_sel with wrp_data at the edge when wrp_en=1.
REQ-021 An inc/dec SHALL replace pair idp_sel with its current value +1 or -1, modulo 2^(2*WIDTH), at the edge when idp_en=1.
REQ-022 Inc/dec SHALL wrap in both directions: FFFF+1 gives 0000 and 0000-1 gives FFFF for WIDTH=8.
REQ-023 When operations target the same byte in one cycle, byte priority SHALL be wrp > idp > wr.
REQ-024 For an overlapping idp and wr, the losing wr byte SHALL be dropped and the other idp byte SHALL still update.
REQ-025 When wrp and idp target the same pair, the idp SHALL be discarded entirely.
REQ-026 Operations on disjoint bytes in the same cycle SHALL all take effect.
REQ-027 Every path into FLAG_REG SHALL be ANDed with FLAG_MASK before storage.
REQ-028 rd_*_data for FLAG_REG SHALL therefore never show non-mask bits.
REQ-029 Inc/dec of the pair containing FLAG_REG SHALL compute on the stored (masked) value and then mask the result.
REQ-030 A wr_sel that is out of range (>= NUM_REGS) SHALL be ignored.
REQ-031 An out-of-range byte read SHALL return 0.
REQ-032 Pair selects SHALL never be out of range, since NUM_REGS/2 is a power of two; if it is not, out-of-range pair ops SHALL be ignored and read 0.
REQ-033 Each operation SHALL have single-cycle latency; there is no busy or stall state.
REQ-034 zero SHALL be combinational and SHALL not reflect same-cycle updates.

Reset
REQ-035 While rst=1 at an edge, all registers SHALL become 0, and all write, pair write and inc/dec requests that cycle SHALL be ignored.
REQ-036 After reset all read data SHALL be 0 and zero SHALL be 1 for any idp_sel.
REQ-037 Reset asserted mid-sequence SHALL take effect at the next edge, and no partial pair update SHALL survive.

Verification
REQ-038 Scenario: rst for 1 cycle, then read every index -> all reads 0, and rdp_data = 0000 for every pair.
REQ-039 Scenario: wrp_sel=0 with wrp_data=12FF, then read -> rd A = 12, rd F = F0, rdp_data = 12F0.
REQ-040 Scenario: HL=FFFF then idp inc -> 0000 and zero=1; then idp_dec=1 -> FFFF.
REQ-041 Scenario: same cycle wr_sel=7 (L) with wr_data=55 and idp inc on HL=00FF -> HL = 0100 (the wr is dropped); next cycle wr L=55 alone -> HL = 0155.
REQ-042 Scenario: same cycle wrp BC=ABCD, idp dec BC, and wr_sel=4 (H) with 77 -> BC = ABCD, H = 77.
REQ-043 Scenario: rst asserted together with wrp_en, then deassert -> all registers 0, and the write is not applied.
